// File: rtl/tmds_pkg.sv
// Shared definitions for the TMDS lane encoder.
//   tmds_mode_e  : lane period type, carried through the stage-1 register
//   CTRL_CODE    : control-period symbols indexed by {c1,c0}
//   TERC4_CODE   : data-island symbols indexed by the 4-bit nibble
//   VGUARD_CODE  : video guard-band symbol per channel
//   IGUARD_CODE  : island guard-band symbol per channel (ch0 entry unused)
//   n_ones8()    : population count of a byte
package tmds_pkg;

  typedef enum logic [2:0] {
    MODE_CTRL   = 3'd0,
    MODE_VIDEO  = 3'd1,
    MODE_VGUARD = 3'd2,
    MODE_ISLAND = 3'd3,
    MODE_IGUARD = 3'd4
  } tmds_mode_e;

  localparam logic [9:0] CTRL_CODE [4] = '{
    10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011
  };

  localparam logic [9:0] TERC4_CODE [16] = '{
    10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
    10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
  };

  localparam logic [9:0] VGUARD_CODE [3] = '{
    10'b1011001100, 10'b0100110011, 10'b1011001100
  };

  // Channel 0 island guard carries hsync/vsync through TERC4, so its entry
  // here is unused and never selected.
  localparam logic [9:0] IGUARD_CODE [3] = '{
    10'b0000000000, 10'b0100110011, 10'b0100110011
  };

  function automatic logic [3:0] n_ones8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + 4'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/tmds_qm_stage.sv
// Stage 1 of the TMDS video path: transition-minimised word q_m and its
// ones count, both registered.
//   clk, rst_n : pixel clock, asynchronous active-low reset
//   vd_i       : 8-bit video data
//   qm_o       : registered q_m[8:0]; bit 8 = 1 means XOR chaining was used
//   n1_o       : registered number of ones in q_m[7:0]
module tmds_qm_stage
  import tmds_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] vd_i,
  output logic [8:0] qm_o,
  output logic [3:0] n1_o
);

  logic [3:0] n1_vd;
  logic       use_xnor;
  logic [8:0] qm_d;
  logic [3:0] n1_d;
  logic [8:0] qm_q;
  logic [3:0] n1_q;

  // NOTE: every signal written in an always_comb gets a default before any
  // branch, otherwise an unassigned path infers a latch.
  always_comb begin
    qm_d     = '0;
    n1_vd    = n_ones8(vd_i);
    // The tie-break on vd[0] keeps the choice deterministic at N1 == 4.
    use_xnor = (n1_vd > 4'd4) || ((n1_vd == 4'd4) && !vd_i[0]);
    qm_d[0]  = vd_i[0];
    for (int i = 1; i < 8; i++) begin
      qm_d[i] = use_xnor ? ~(qm_d[i-1] ^ vd_i[i]) : (qm_d[i-1] ^ vd_i[i]);
    end
    qm_d[8]  = ~use_xnor;
    n1_d     = n_ones8(qm_d[7:0]);
  end

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qm_q <= '0;
      n1_q <= '0;
    end else begin
      qm_q <= qm_d;
      n1_q <= n1_d;
    end
  end

  assign qm_o = qm_q;
  assign n1_o = n1_q;

endmodule

// File: rtl/tmds_lane_encoder.sv
// One HDMI TMDS lane: DVI 8b/10b video with running disparity, plus control,
// video guard, TERC4 data island and island guard periods. Two-stage
// pipeline, one symbol per pixel clock, 2 cycles input-to-output.
//   video_clk_pix, video_rst_n : pixel clock, asynchronous active-low reset
//   mode      : period type (tmds_mode_e encoding; 5..7 treated as control)
//   vd        : video byte          cd  : control bits {c1,c0}
//   aux       : TERC4 nibble        tmds: 10-bit symbol, bit 0 first
//   disparity : running disparity after the symbol currently on tmds
module tmds_lane_encoder
  import tmds_pkg::*;
#(
  parameter int CHANNEL     = 0,
  parameter int CNT_W       = 5,
  parameter int INVERT_LANE = 0
) (
  input  logic             video_clk_pix,
  input  logic             video_rst_n,
  input  logic [2:0]       mode,
  input  logic [7:0]       vd,
  input  logic [1:0]       cd,
  input  logic [3:0]       aux,
  output logic [9:0]       tmds,
  output logic [CNT_W-1:0] disparity
);

  localparam logic signed [CNT_W-1:0] ZERO  = '0;
  localparam logic signed [CNT_W-1:0] TWO   = CNT_W'(2);
  localparam logic signed [CNT_W-1:0] EIGHT = CNT_W'(8);
  localparam logic [9:0] TMDS_RST = (INVERT_LANE != 0) ? ~CTRL_CODE[0] : CTRL_CODE[0];

  // ---------------- stage 1 ----------------
  tmds_mode_e mode_d, mode_q;
  logic [1:0] cd_q;
  logic [3:0] aux_q;
  logic [8:0] qm;
  logic [3:0] n1;

  tmds_qm_stage u_qm (
    .clk   (video_clk_pix),
    .rst_n (video_rst_n),
    .vd_i  (vd),
    .qm_o  (qm),
    .n1_o  (n1)
  );

  always_comb begin
    case (mode)
      MODE_VIDEO, MODE_VGUARD, MODE_ISLAND, MODE_IGUARD: mode_d = tmds_mode_e'(mode);
      default:                                           mode_d = MODE_CTRL;
    endcase
  end

  always_ff @(posedge video_clk_pix or negedge video_rst_n) begin
    if (!video_rst_n) begin
      mode_q <= MODE_CTRL;
      cd_q   <= '0;
      aux_q  <= '0;
    end else begin
      mode_q <= mode_d;
      cd_q   <= cd;
      aux_q  <= aux;
    end
  end

  // ---------------- stage 2 ----------------
  logic signed [CNT_W-1:0] cnt_d, cnt_q;
  logic signed [CNT_W-1:0] n1_s, d_s;
  logic [9:0] sym, tmds_d, tmds_q;
  logic       q8, cnt_zero, cnt_neg, d_zero, d_neg;

  always_comb begin
    sym      = CTRL_CODE[cd_q];
    cnt_d    = ZERO;
    q8       = qm[8];
    // d = N1 - N0 = 2*N1 - 8, computed modulo 2^CNT_W.
    n1_s     = signed'(CNT_W'(n1));
    d_s      = (n1_s <<< 1) - EIGHT;
    cnt_zero = (cnt_q == ZERO);
    cnt_neg  = cnt_q[CNT_W-1];
    d_zero   = (d_s == ZERO);
    d_neg    = d_s[CNT_W-1];
    case (mode_q)
      MODE_VIDEO: begin
        if (cnt_zero || d_zero) begin
          sym   = {~q8, q8, q8 ? qm[7:0] : ~qm[7:0]};
          cnt_d = q8 ? (cnt_q + d_s) : (cnt_q - d_s);
        end else if (cnt_neg == d_neg) begin
          // Running disparity and this word lean the same way: invert it.
          sym   = {1'b1, q8, ~qm[7:0]};
          cnt_d = cnt_q + (q8 ? TWO : ZERO) - d_s;
        end else begin
          sym   = {1'b0, q8, qm[7:0]};
          cnt_d = cnt_q + d_s - (q8 ? ZERO : TWO);
        end
      end
      MODE_VGUARD: sym = VGUARD_CODE[CHANNEL];
      MODE_ISLAND: sym = TERC4_CODE[aux_q];
      MODE_IGUARD: sym = (CHANNEL == 0) ? TERC4_CODE[{2'b11, cd_q}] : IGUARD_CODE[CHANNEL];
      default:     sym = CTRL_CODE[cd_q];
    endcase
    tmds_d = (INVERT_LANE != 0) ? ~sym : sym;
  end

  always_ff @(posedge video_clk_pix or negedge video_rst_n) begin
    if (!video_rst_n) begin
      tmds_q <= TMDS_RST;
      cnt_q  <= ZERO;
    end else begin
      tmds_q <= tmds_d;
      cnt_q  <= cnt_d;
    end
  end

  assign tmds      = tmds_q;
  assign disparity = cnt_q;

endmodule

// File: tb/tb_tmds_lane_encoder.sv
// Bench for tmds_lane_encoder: three lanes (ch0, ch1, ch2 inverted) driven
// by one stimulus stream and checked every cycle against a behavioural model
// of the TMDS rules, plus hand-computed literal symbols.
module tb_tmds_lane_encoder;

  localparam logic [9:0] T_CTRL [4]  = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
  localparam logic [9:0] T_TERC [16] = '{
    10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
    10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
  };
  localparam logic [9:0] T_GUARD_A = 10'b1011001100;
  localparam logic [9:0] T_GUARD_B = 10'b0100110011;
  localparam bit INV [3] = '{1'b0, 1'b0, 1'b1};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] mode = 3'd0;
  logic [7:0] vd = 8'h00;
  logic [1:0] cd = 2'b00;
  logic [3:0] aux = 4'h0;
  logic [9:0] tmds_w [3];
  logic [4:0] disp_w [3];

  always #5 clk = ~clk;

  tmds_lane_encoder #(.CHANNEL(0), .CNT_W(5), .INVERT_LANE(0)) dut0 (
    .video_clk_pix(clk), .video_rst_n(rst_n), .mode(mode), .vd(vd), .cd(cd),
    .aux(aux), .tmds(tmds_w[0]), .disparity(disp_w[0]));
  tmds_lane_encoder #(.CHANNEL(1), .CNT_W(5), .INVERT_LANE(0)) dut1 (
    .video_clk_pix(clk), .video_rst_n(rst_n), .mode(mode), .vd(vd), .cd(cd),
    .aux(aux), .tmds(tmds_w[1]), .disparity(disp_w[1]));
  tmds_lane_encoder #(.CHANNEL(2), .CNT_W(5), .INVERT_LANE(1)) dut2 (
    .video_clk_pix(clk), .video_rst_n(rst_n), .mode(mode), .vd(vd), .cd(cd),
    .aux(aux), .tmds(tmds_w[2]), .disparity(disp_w[2]));

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int drv_cyc = 0;
  bit chk_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int lane, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s lane%0d cyc%0d: got %0h expected %0h", name, lane, cyc, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic void video_encode(input logic [7:0] v, input int cnt_in,
                                       output logic [9:0] s, output int cnt_out);
    int ones;
    bit use_xnor;
    logic [8:0] q;
    int n1;
    int d;
    ones     = $countones(v);
    use_xnor = (ones > 4) || (ones == 4 && v[0] == 1'b0);
    q[0]     = v[0];
    for (int i = 1; i < 8; i++) q[i] = use_xnor ? (q[i-1] ~^ v[i]) : (q[i-1] ^ v[i]);
    q[8]     = !use_xnor;
    n1       = $countones(q[7:0]);
    d        = n1 - (8 - n1);
    if (cnt_in == 0 || d == 0) begin
      s       = {~q[8], q[8], q[8] ? q[7:0] : ~q[7:0]};
      cnt_out = q[8] ? cnt_in + d : cnt_in - d;
    end else if ((cnt_in > 0 && d > 0) || (cnt_in < 0 && d < 0)) begin
      s       = {1'b1, q[8], ~q[7:0]};
      cnt_out = cnt_in + 2 * int'(q[8]) - d;
    end else begin
      s       = {1'b0, q[8], q[7:0]};
      cnt_out = cnt_in + d - 2 * int'(!q[8]);
    end
  endfunction

  logic [2:0] s1_mode = 3'd0;
  logic [7:0] s1_vd = 8'h00;
  logic [1:0] s1_cd = 2'b00;
  logic [3:0] s1_aux = 4'h0;
  int         m_cnt = 0;
  bit         m_video = 1'b0;
  logic [9:0] exp_sym [3] = '{10'h354, 10'h354, 10'h0AB};

  initial begin
    logic [9:0] vsym;
    int         ncnt;
    logic [9:0] base;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        s1_mode = 3'd0; s1_vd = 8'h00; s1_cd = 2'b00; s1_aux = 4'h0;
        m_cnt = 0; m_video = 1'b0;
        for (int k = 0; k < 3; k++) exp_sym[k] = INV[k] ? ~T_CTRL[0] : T_CTRL[0];
      end else begin
        m_video = (s1_mode == 3'd1);
        vsym = '0;
        ncnt = 0;
        if (m_video) video_encode(s1_vd, m_cnt, vsym, ncnt);
        m_cnt = ncnt;
        for (int k = 0; k < 3; k++) begin
          case (s1_mode)
            3'd1:    base = vsym;
            3'd2:    base = (k == 1) ? T_GUARD_B : T_GUARD_A;
            3'd3:    base = T_TERC[s1_aux];
            3'd4:    base = (k == 0) ? T_TERC[{2'b11, s1_cd}] : T_GUARD_B;
            default: base = T_CTRL[s1_cd];
          endcase
          exp_sym[k] = INV[k] ? ~base : base;
        end
        s1_mode = mode; s1_vd = vd; s1_cd = cd; s1_aux = aux;
      end
    end
  end

  // ---------------- literal pins (lane 0 and lane 1) ----------------
  logic [9:0] lit0_sym [int];
  int         lit0_dsp [int];
  logic [9:0] lit1_sym [int];

  // ---------------- compare process ----------------
  initial begin
    int prev_disp [3] = '{0, 0, 0};
    int dnow;
    logic [9:0] raw;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int k = 0; k < 3; k++) begin
          dnow = int'($signed(disp_w[k]));
          check("tmds", k, int'(tmds_w[k]), int'(exp_sym[k]));
          check("disparity", k, dnow, m_cnt);
          if (m_video) begin
            raw = INV[k] ? ~tmds_w[k] : tmds_w[k];
            check("dc_delta", k, 2 * $countones(raw) - 10, dnow - prev_disp[k]);
            check("disp_bound", k, int'(dnow >= -10 && dnow <= 10), 1);
          end
          prev_disp[k] = dnow;
        end
        if (lit0_sym.exists(cyc)) begin
          check("lit_tmds", 0, int'(tmds_w[0]), int'(lit0_sym[cyc]));
          check("lit_disp", 0, int'($signed(disp_w[0])), lit0_dsp[cyc]);
          check("model_pin", 0, int'(exp_sym[0]), int'(lit0_sym[cyc]));
        end
        if (lit1_sym.exists(cyc)) begin
          check("lit_tmds", 1, int'(tmds_w[1]), int'(lit1_sym[cyc]));
          check("model_pin", 1, int'(exp_sym[1]), int'(lit1_sym[cyc]));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic [2:0] m, input logic [7:0] v, input logic [1:0] c,
                       input logic [3:0] a);
    @(posedge clk);
    #1;
    mode = m; vd = v; cd = c; aux = a;
    drv_cyc = cyc;
  endtask

  task automatic pin0(input logic [9:0] s, input int dsp);
    lit0_sym[drv_cyc + 2] = s;
    lit0_dsp[drv_cyc + 2] = dsp;
  endtask

  task automatic pin1(input logic [9:0] s);
    lit1_sym[drv_cyc + 2] = s;
  endtask

  initial begin
    // 1. reset held, then released into CTRL cd=00
    @(posedge clk);
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    drv_cyc = cyc;
    lit0_sym[drv_cyc + 1] = 10'h354; lit0_dsp[drv_cyc + 1] = 0;
    lit0_sym[drv_cyc + 2] = 10'h354; lit0_dsp[drv_cyc + 2] = 0;
    drive(3'd0, 8'h00, 2'b00, 4'h0);

    // 2. VIDEO 00 three times from cnt = 0
    drive(3'd1, 8'h00, 2'b00, 4'h0); pin0(10'h100, -8);
    drive(3'd1, 8'h00, 2'b00, 4'h0); pin0(10'h3FF, 2);
    drive(3'd1, 8'h00, 2'b00, 4'h0); pin0(10'h100, -6);

    // 3. VIDEO burst, CTRL 11 clears cnt, next VIDEO 00 restarts at 0
    drive(3'd1, 8'hA5, 2'b00, 4'h0);
    drive(3'd1, 8'h3C, 2'b00, 4'h0);
    drive(3'd1, 8'hFF, 2'b00, 4'h0);
    drive(3'd0, 8'h00, 2'b11, 4'h0); pin0(10'h2AB, 0);
    drive(3'd1, 8'h00, 2'b00, 4'h0); pin0(10'h100, -8);

    // 4. TERC4 sweep
    for (int a = 0; a < 16; a++) begin
      drive(3'd3, 8'h00, 2'b00, 4'(a));
      if (a == 0)  pin0(10'b1010011100, 0);
      if (a == 15) pin0(10'b1011000011, 0);
    end

    // 5. guard bands and out-of-range modes
    drive(3'd4, 8'h00, 2'b10, 4'h0); pin0(10'b0101100011, 0); pin1(10'b0100110011);
    drive(3'd2, 8'h00, 2'b00, 4'h0); pin0(10'b1011001100, 0); pin1(10'b0100110011);
    drive(3'd5, 8'h00, 2'b01, 4'h0); pin0(10'h0AB, 0);
    drive(3'd7, 8'h00, 2'b10, 4'h0); pin0(10'h154, 0);

    // reset mid-VIDEO: outputs return immediately, pipeline flushed
    drive(3'd1, 8'h12, 2'b00, 4'h0);
    drive(3'd1, 8'hF0, 2'b00, 4'h0);
    drive(3'd1, 8'h81, 2'b00, 4'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_tmds", 0, int'(tmds_w[0]), 10'h354);
    check("async_rst_disp", 0, int'(disp_w[0]), 0);
    check("async_rst_tmds", 2, int'(tmds_w[2]), 10'h0AB);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    mode = 3'd0; vd = 8'h00; cd = 2'b00; aux = 4'h0;
    drv_cyc = cyc;
    lit0_sym[drv_cyc + 1] = 10'h354; lit0_dsp[drv_cyc + 1] = 0;
    lit0_sym[drv_cyc + 2] = 10'h354; lit0_dsp[drv_cyc + 2] = 0;

    // mixed periods with random data
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'd1,
            8'($urandom), 2'($urandom), 4'($urandom));
    end

    // 6. long random VIDEO run
    for (int i = 0; i < 10000; i++) drive(3'd1, 8'($urandom), 2'b00, 4'h0);

    repeat (3) drive(3'd0, 8'h00, 2'b00, 4'h0);
    @(negedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
